alu_flag_stage: RTL and testbench
=================================

Name: alu_flag_stage

Overview:
Registered output stage placed directly downstream of the ALU result multiplexer. It captures the selected result and its opcode, derives the N/Z/C/V status flags, and presents result and flags over a valid/ready interface. A 2-entry skid buffer decouples upstream from downstream backpressure. It also keeps a sticky illegal-opcode error bit.

Parameters:
W, 4, datapath width; result width and opcode width (opcode is W bits wide)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a result this cycle
in_ready  output  1  stage can accept a beat
in_opcode  input  W  opcode that produced in_result (alu_ops encoding)
in_result  input  W  multiplexer output
in_carry  input  1  raw carry: adder carry-out for ADD, no-borrow for SUB, last bit shifted out for shifts
in_overflow  input  1  raw signed overflow from the adder or arithmetic-left shifter
out_valid  output  1  out_* fields hold a valid beat
out_ready  input  1  downstream accepts the beat
out_result  output  W  registered result
out_flags  output  4  {N,Z,C,V}
err_illegal  output  1  sticky: an unknown opcode was accepted
err_clr  input  1  synchronous clear of err_illegal

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_result=0, out_flags=0, err_illegal=0, skid empty. in_ready=0 while reset is asserted and 1 from the first clock edge after release. Reset mid-transfer drops all held beats.
- Handshake: an input beat transfers when in_valid&&in_ready. An output beat transfers when out_valid&&out_ready.
- While out_valid=1 and out_ready=0, out_result and out_flags stay stable.
- Latency: an accepted beat appears on out_* on the next cycle if the output register is empty or being drained. Throughput is 1 beat/cycle.
- Skid: 2 entries (output register plus one skid register).
  - If a beat is accepted while the output register is held, the beat goes to the skid register.
  - in_ready is registered and is 0 whenever the skid register is occupied.
  - When the output drains, the skid entry moves to the output register in the same edge. in_ready rises one cycle later.
  - Beats are never dropped, duplicated or reordered.
- Flags are computed combinationally at the input and stored with the beat:
  - N = in_result[W-1]
  - Z = (in_result == 0)
  - C = in_carry for ADD, SUB, LL_SHIFT, LR_SHIFT, AL_SHIFT, AR_SHIFT; otherwise 0
  - V = in_overflow for ADD, SUB, AL_SHIFT; otherwise 0
- Unknown opcode: the beat still passes through with flags forced to 0, and err_illegal sets on acceptance.
- err_illegal: err_clr wins over a same-cycle set, and the bit remains 0 that cycle. err_illegal holds until cleared or reset.
- No combinational path from out_ready to in_ready.

Decomposition:
- alu_ops package: existing opcode constants, plus:
  - typedef alu_flags_t, a packed struct {n,z,c,v}
  - function is_legal_op(opcode)
  - functions op_uses_carry(opcode) and op_uses_overflow(opcode)
- Sub-module alu_flag_calc: combinational; takes opcode, result, carry, overflow; produces alu_flags_t and illegal. This module is reused by the future status register.
- The skid and handshake logic stays inline in alu_flag_stage.

Test Plan:
- ADD_OP, in_result=4'h8, in_carry=0, in_overflow=1, out_ready=1 -> next cycle out_valid=1, out_result=8, flags N=1 Z=0 C=0 V=1.
- SUB_OP, in_result=4'h0, in_carry=1, in_overflow=0 -> flags N=0 Z=1 C=1 V=0.
- AND_OP, in_result=4'h0, in_carry=1, in_overflow=1 -> flags N=0 Z=1 C=0 V=0 (carry and overflow masked).
- Backpressure:
  - stimulus: stream 5,6,7 back-to-back with out_ready=0 from cycle 1
  - out_result holds 5 stable
  - in_ready=0 after 6 is accepted, and 7 is held upstream
  - release out_ready -> output order 5,6,7 with no loss or duplicates
- Opcode 4'hF with in_result=4'h3 -> out_result=3, flags 0, err_illegal=1 next cycle. err_clr pulse concurrent with a second illegal beat -> err_illegal=0.
- Assert rst_n=0 asynchronously with both entries full -> out_valid=0, out_flags=0 immediately. After release, in_ready=1 at the next edge and no stale beat appears.

Source files
------------

// File: rtl/alu_ops_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ops (package)
//  Brief    : ALU opcode constants, status-flag bundle type and opcode
//             classification helpers shared by the ALU output stages.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_ops;

    // Opcode encoding. Every code not listed here is illegal.
    localparam logic [3:0] ADD_OP   = 4'h0;
    localparam logic [3:0] SUB_OP   = 4'h1;
    localparam logic [3:0] AND_OP   = 4'h2;
    localparam logic [3:0] OR_OP    = 4'h3;
    localparam logic [3:0] XOR_OP   = 4'h4;
    localparam logic [3:0] NOT_OP   = 4'h5;
    localparam logic [3:0] LL_SHIFT = 4'h6;
    localparam logic [3:0] LR_SHIFT = 4'h7;
    localparam logic [3:0] AL_SHIFT = 4'h8;
    localparam logic [3:0] AR_SHIFT = 4'h9;

    // Status flags in {N,Z,C,V} order, N is the MSB.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    // Opcodes are passed zero-extended to 32 bits so any datapath width works.
    function automatic logic is_legal_op(input logic [31:0] op);
        return (op <= 32'(AR_SHIFT));
    endfunction

    // Operations whose raw carry is architecturally meaningful.
    function automatic logic op_uses_carry(input logic [31:0] op);
        return (op == 32'(ADD_OP))   || (op == 32'(SUB_OP))   ||
               (op == 32'(LL_SHIFT)) || (op == 32'(LR_SHIFT)) ||
               (op == 32'(AL_SHIFT)) || (op == 32'(AR_SHIFT));
    endfunction

    // Operations that can produce a signed overflow.
    function automatic logic op_uses_overflow(input logic [31:0] op);
        return (op == 32'(ADD_OP)) || (op == 32'(SUB_OP)) ||
               (op == 32'(AL_SHIFT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_stage_calc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flag_calc
//  Brief    : Combinational N/Z/C/V derivation from an ALU result, its opcode
//             and the raw carry/overflow. Flags are all zero for an illegal
//             opcode, which is also reported on 'illegal'.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flag_calc
    import alu_ops::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] opcode,
    input  logic [W-1:0] result,
    input  logic         carry,
    input  logic         overflow,
    output alu_flags_t   flags,
    output logic         illegal
);

    logic [31:0] w_op;
    logic        w_legal;

    assign w_op    = 32'(opcode);
    assign w_legal = is_legal_op(w_op);
    assign illegal = !w_legal;

    // Mask each flag by opcode legality and by whether the opcode defines it.
    always_comb begin
        flags   = '0;
        if (w_legal) begin
            flags.n = result[W-1];
            flags.z = (result == '0);
            flags.c = carry    && op_uses_carry(w_op);
            flags.v = overflow && op_uses_overflow(w_op);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flag_stage
//  Brief    : Registered ALU output stage. Captures result and derived
//             flags behind a valid/ready interface with a 2-entry skid
//             buffer, and keeps a sticky illegal-opcode error bit.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flag_stage
    import alu_ops::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_opcode,
    input  logic [W-1:0] in_result,
    input  logic         in_carry,
    input  logic         in_overflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_flags,
    output logic         err_illegal,
    input  logic         err_clr
);

    alu_flags_t   w_flags;
    logic         w_illegal;
    logic         w_acc;
    logic         w_out_free;

    logic         r_in_ready;
    logic         r_out_valid;
    logic [W-1:0] r_out_result;
    alu_flags_t   r_out_flags;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_result;
    alu_flags_t   r_skid_flags;
    logic         r_err;

    alu_flag_calc #(
        .W (W)
    ) u_calc (
        .opcode   (in_opcode),
        .result   (in_result),
        .carry    (in_carry),
        .overflow (in_overflow),
        .flags    (w_flags),
        .illegal  (w_illegal)
    );

    assign w_acc      = in_valid && r_in_ready;
    // Output register can take a new beat this edge (empty or being drained).
    assign w_out_free = !r_out_valid || out_ready;

    // Output/skid datapath; in_ready is a pure function of next skid occupancy
    // so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_flags   <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_flags  <= '0;
        end else if (w_out_free) begin
            // Skid occupied implies in_ready was low, so no new beat competes.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_result <= r_skid_result;
                r_out_flags  <= r_skid_flags;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_out_valid  <= 1'b1;
                r_out_result <= in_result;
                r_out_flags  <= w_flags;
            end else begin
                r_out_valid  <= 1'b0;
            end
            r_in_ready <= 1'b1;
        end else if (w_acc) begin
            r_skid_valid  <= 1'b1;
            r_skid_result <= in_result;
            r_skid_flags  <= w_flags;
            r_in_ready    <= 1'b0;
        end else begin
            r_in_ready <= !r_skid_valid;
        end
    end

    // Sticky illegal-opcode bit; clear has priority over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end else if (w_acc && w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_flags   = r_out_flags;
    assign err_illegal = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_flag_stage
//  Brief    : Scoreboard bench for alu_flag_stage: directed scenarios then
//             randomized traffic, checked against a flag reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_stage;
    import alu_ops::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_opcode = '0;
    logic [W-1:0] in_result = '0;
    logic         in_carry = 1'b0;
    logic         in_overflow = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;
    logic         err_illegal;
    logic         err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];          // {result, flags} of beats held by the DUT
    logic       ref_err = 1'b0;
    int         edges_since_rst = 0;
    logic       prev_hold = 1'b0;
    logic [W-1:0] prev_result;
    logic [3:0]   prev_flags;

    alu_flag_stage #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .err_illegal (err_illegal),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges_since_rst = 0;
        else        edges_since_rst = edges_since_rst + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flag rules: {N,Z,C,V}; illegal opcodes yield all zeros.
    function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [3:0] res,
                                             input logic c, input logic v);
        logic n, z, cf, vf;
        if (op > 4'd9) return 4'b0000;
        n  = res[3];
        z  = (res == 4'd0);
        cf = (op inside {ADD_OP, SUB_OP, LL_SHIFT, LR_SHIFT, AL_SHIFT, AR_SHIFT}) ? c : 1'b0;
        vf = (op inside {ADD_OP, SUB_OP, AL_SHIFT}) ? v : 1'b0;
        return {n, z, cf, vf};
    endfunction

    // Monitor: checks state at the falling edge, then records the handshakes
    // that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            ref_err   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (edges_since_rst == 0) check("in_ready_after_release", 32'(in_ready), 32'd0);
            else                      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
            check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
            check("err_illegal", 32'(err_illegal), 32'(ref_err));
            if (prev_hold) begin
                check("hold_result", 32'(out_result), 32'(prev_result));
                check("hold_flags", 32'(out_flags), 32'(prev_flags));
            end
            prev_hold   = out_valid && !out_ready;
            prev_result = out_result;
            prev_flags  = out_flags;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(out_result), 32'hDEAD);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    check("beat_result", 32'(out_result), 32'(e[7:4]));
                    check("beat_flags", 32'(out_flags), 32'(e[3:0]));
                end
            end
            if (in_valid && in_ready)
                sb.push_back({in_result, ref_flags(in_opcode, in_result, in_carry, in_overflow)});
            if (err_clr) ref_err = 1'b0;
            else if (in_valid && in_ready && in_opcode > 4'd9) ref_err = 1'b1;
        end
    end

    // Present a beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [3:0] res, input logic c, input logic v);
        int cyc = 0;
        in_valid = 1'b1; in_opcode = op; in_result = res; in_carry = c; in_overflow = v;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            cyc++;
            if (cyc > 50) begin
                check("send_timeout", 32'(cyc), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed flag cases.
        out_ready = 1'b1;
        send(ADD_OP, 4'h8, 1'b0, 1'b1);
        check("add_result", 32'(out_result), 32'h8);
        check("add_flags", 32'(out_flags), 32'b1001);
        send(SUB_OP, 4'h0, 1'b1, 1'b0);
        check("sub_flags", 32'(out_flags), 32'b0110);
        send(AND_OP, 4'h0, 1'b1, 1'b1);
        check("and_flags", 32'(out_flags), 32'b0100);
        @(posedge clk); #1;

        // Backpressure: 5 to output, 6 to skid, 7 held upstream.
        out_ready = 1'b0;
        send(ADD_OP, 4'h5, 1'b0, 1'b0);
        send(ADD_OP, 4'h6, 1'b0, 1'b0);
        check("bp_out_5", 32'(out_result), 32'h5);
        in_valid = 1'b1; in_opcode = ADD_OP; in_result = 4'h7;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_stable", 32'(out_result), 32'h5);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(ADD_OP, 4'h7, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Illegal opcode and clear-over-set priority.
        send(4'hF, 4'h3, 1'b1, 1'b1);
        check("ill_result", 32'(out_result), 32'h3);
        check("ill_flags", 32'(out_flags), 32'h0);
        check("ill_err_set", 32'(err_illegal), 32'd1);
        err_clr = 1'b1;
        send(4'hF, 4'h3, 1'b0, 1'b0);
        err_clr = 1'b0;
        check("ill_err_clr_wins", 32'(err_illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and occasional clears.
        repeat (3000) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_opcode   = 4'($urandom_range(0, 15));
            in_result   = 4'($urandom_range(0, 15));
            in_carry    = 1'($urandom_range(0, 1));
            in_overflow = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            err_clr     = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with both entries full.
        out_ready = 1'b0;
        send(ADD_OP, 4'h9, 1'b1, 1'b1);
        send(SUB_OP, 4'hA, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_flags", 32'(out_flags), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
